// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DEF_DATA_BITS = 8;
    localparam int unsigned MIN_DIV       = 4;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a registered falling-edge flag.
// Flops reset to the idle-high line level so reset release never fakes a start.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic rx,
    output logic rx_s,
    output logic fall_s
);

    logic meta;

    // fall_s rises together with the synchronized low level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta   <= 1'b1;
            rx_s   <= 1'b1;
            fall_s <= 1'b0;
        end else begin
            meta   <= rx;
            rx_s   <= meta;
            fall_s <= rx_s & ~meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime baud divisor, framing-error and break detection.
// Define UART_RX_PARITY_EN to add a parity bit and the o_parity_err check.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned DIV_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic [DIV_W-1:0]     i_clk_div,
    input  logic                 i_parity_odd,
    output logic                 o_busy,
    output logic                 o_data_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_break
);

    localparam int unsigned      BIT_W    = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(MIN_DIV);

    rx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_in;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d, ferr_d, brk_d;
    logic                 rx_s, fall_s, tick;

    uart_rx_sync u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .rx     (i_rx),
        .rx_s   (rx_s),
        .fall_s (fall_s)
    );

    // Out-of-range divisors are clamped so the half-bit offset stays non-zero
    assign div_in = (i_clk_div < DIV_MIN) ? DIV_MIN : i_clk_div;
    assign tick   = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, perr_d, par_exp;
    assign par_exp = (^shift_q) ^ i_parity_odd;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = i_parity_odd;
    assign o_parity_err      = 1'b0;
`endif

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = o_data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (state_q != ST_IDLE) begin
            cnt_d = tick ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_START;
                    div_d   = div_in;
                    cnt_d   = (div_in >> 1) - DIV_W'(1);
`ifdef UART_RX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (rx_s != par_exp) begin
                        par_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_q;
`endif
                    end else begin
                        state_d = ST_WAIT_IDLE;
                        ferr_d  = 1'b1;
                        brk_d   = (shift_q == '0);
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Any low sample restarts the full high-time requirement
                if (!rx_s) begin
                    cnt_d = div_q - DIV_W'(1);
                end else if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= DIV_MIN;
            bit_q        <= '0;
            shift_q      <= '0;
            o_data       <= '0;
            o_busy       <= 1'b0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            o_data       <= data_d;
            o_busy       <= (state_d != ST_IDLE);
            o_data_valid <= valid_d;
            o_frame_err  <= ferr_d;
            o_break      <= brk_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            par_q        <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            par_q        <= par_d;
            o_parity_err <= perr_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: vector table, corner sequences, random frame stream.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int DB = 8;
    localparam int DW = 16;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_rx;
    logic [DW-1:0] i_clk_div;
    logic          i_parity_odd;
    logic          o_busy, o_data_valid, o_frame_err, o_parity_err, o_break;
    logic [DB-1:0] o_data;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int act_v[$], act_d[$], act_f[$], act_b[$], act_p[$];
    int exp_v[$], exp_d[$], exp_f[$], exp_b[$], exp_p[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         div;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_brk;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    uart_rx_cfg #(.DATA_BITS(DB), .DIV_W(DW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .i_clk_div    (i_clk_div),
        .i_parity_odd (i_parity_odd),
        .o_busy       (o_busy),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_break      (o_break)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Record every output pulse cycle, sampled away from the active edge
    always @(negedge i_clk) begin
        if (o_data_valid) begin
            act_v.push_back(cyc);
            act_d.push_back(int'(o_data));
        end
        if (o_frame_err)  act_f.push_back(cyc);
        if (o_break)      act_b.push_back(cyc);
        if (o_parity_err) act_p.push_back(cyc);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp);
        n_checks++;
        if (act < exp - 1 || act > exp + 1) begin
            n_fail++;
            $display("FAIL %s: got cycle %0d, expected %0d +/-1", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Cycles from the line falling edge to the result pulse
    function automatic int lat(input int div);
        return 3 + div / 2 + (DB + 1 + P) * div;
    endfunction

    // Drive one frame; called aligned 1ns after a rising edge, returns aligned
    task automatic send_frame(input logic [7:0] data, input logic stop, input int div,
                              input logic par, output int t0);
        t0        = cyc;
        i_clk_div = DW'(div);
        i_rx      = 1'b0;
        tick(div);
        i_clk_div = DW'($urandom_range(4, 60));
        for (int i = 0; i < DB; i++) begin
            i_rx = data[i];
            tick(div);
        end
        if (P == 1) begin
            i_rx = par;
            tick(div);
        end
        i_rx = stop;
        tick(div);
        i_rx = 1'b1;
    endtask

    // Reference outcome of a frame from its line-level content
    task automatic expect_frame(input int t0, input logic [7:0] data, input logic stop,
                                input int div, input logic par_ok);
        int t;
        t = t0 + lat(div);
        if (stop) begin
            exp_v.push_back(t);
            exp_d.push_back(int'(data));
            if (P == 1 && !par_ok) exp_p.push_back(t);
        end else begin
            exp_f.push_back(t);
            if (data == 8'h00) exp_b.push_back(t);
        end
    endtask

    task automatic compare_all(input string name);
        check({name, " valid count"}, act_v.size(), exp_v.size());
        for (int i = 0; i < act_v.size() && i < exp_v.size(); i++) begin
            check_near({name, " valid cycle"}, act_v[i], exp_v[i]);
            check({name, " valid data"}, act_d[i], exp_d[i]);
        end
        check({name, " frame_err count"}, act_f.size(), exp_f.size());
        for (int i = 0; i < act_f.size() && i < exp_f.size(); i++)
            check_near({name, " frame_err cycle"}, act_f[i], exp_f[i]);
        check({name, " break count"}, act_b.size(), exp_b.size());
        for (int i = 0; i < act_b.size() && i < exp_b.size(); i++)
            check_near({name, " break cycle"}, act_b[i], exp_b[i]);
        check({name, " parity_err count"}, act_p.size(), exp_p.size());
        for (int i = 0; i < act_p.size() && i < exp_p.size(); i++)
            check_near({name, " parity_err cycle"}, act_p[i], exp_p[i]);
        act_v.delete(); act_d.delete(); act_f.delete(); act_b.delete(); act_p.delete();
        exp_v.delete(); exp_d.delete(); exp_f.delete(); exp_b.delete(); exp_p.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t0, t1, r, div, last_good;
        logic [7:0] d;
        logic       stop, par, par_ok;

        vecs[0] = '{8'hA5, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 16, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h00, 1'b0,  8, 1'b0, 1'b1, 1'b1, 8'hA5};
        vecs[3] = '{8'hFF, 1'b1,  4, 1'b1, 1'b0, 1'b0, 8'hFF};
        vecs[4] = '{8'h00, 1'b1,  5, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{8'h81, 1'b0,  7, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{8'hC3, 1'b1, 23, 1'b1, 1'b0, 1'b0, 8'hC3};

        i_rst        = 1'b1;
        i_rx         = 1'b1;
        i_clk_div    = DW'(16);
        i_parity_odd = 1'b0;
        tick(3);
        check("reset busy",       int'(o_busy),       0);
        check("reset data_valid", int'(o_data_valid), 0);
        check("reset frame_err",  int'(o_frame_err),  0);
        check("reset parity_err", int'(o_parity_err), 0);
        check("reset break",      int'(o_break),      0);
        check("reset data",       int'(o_data),       0);
        i_rst = 1'b0;
        tick(5);

        for (int k = 0; k < 7; k++) begin
            par = (^vecs[k].data) ^ i_parity_odd;
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].div, par, t0);
            if (vecs[k].exp_valid) begin
                exp_v.push_back(t0 + lat(vecs[k].div));
                exp_d.push_back(int'(vecs[k].exp_data));
            end
            if (vecs[k].exp_ferr) exp_f.push_back(t0 + lat(vecs[k].div));
            if (vecs[k].exp_brk)  exp_b.push_back(t0 + lat(vecs[k].div));
            tick(3 * vecs[k].div + 8);
            compare_all($sformatf("vec%0d", k));
            check($sformatf("vec%0d held data", k), int'(o_data), int'(vecs[k].exp_data));
            check($sformatf("vec%0d idle busy", k), int'(o_busy), 0);
        end

        // Short low glitch is rejected at the start-bit sample
        i_clk_div = DW'(16);
        t0   = cyc;
        i_rx = 1'b0;
        tick(3);
        i_rx = 1'b1;
        tick(2);
        check("glitch busy during start", int'(o_busy), 1);
        tick(7);
        check("glitch busy cleared", int'(o_busy), 0);
        tick(20);
        compare_all("glitch");
        check("glitch held data", int'(o_data), 8'hC3);

        // Long break: one error, then a short low inside the high time must not start a frame
        i_clk_div = DW'(16);
        t0   = cyc;
        i_rx = 1'b0;
        tick(640);
        i_rx = 1'b1;
        r    = cyc;
        exp_f.push_back(t0 + lat(16));
        exp_b.push_back(t0 + lat(16));
        tick(8);
        i_rx = 1'b0;
        tick(2);
        i_rx = 1'b1;
        tick(14);
        check("break wait busy", int'(o_busy), 1);
        tick(8);
        check("break recovered busy", int'(o_busy), 0);
        compare_all("break");
        check("break held data", int'(o_data), 8'hC3);
        send_frame(8'h6E, 1'b1, 16, (^8'h6E) ^ i_parity_odd, t0);
        expect_frame(t0, 8'h6E, 1'b1, 16, 1'b1);
        tick(40);
        compare_all("after break");

`ifdef UART_RX_PARITY_EN
        i_parity_odd = 1'b1;
        send_frame(8'h01, 1'b1, 16, 1'b1, t0);
        expect_frame(t0, 8'h01, 1'b1, 16, 1'b0);
        tick(40);
        compare_all("parity odd");
        check("parity data", int'(o_data), 8'h01);
        i_parity_odd = 1'b0;
`endif

        // Reset during bit 4 aborts silently; then two back-to-back frames
        i_clk_div = DW'(10);
        d    = 8'h77;
        i_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            i_rx = d[i];
            tick(10);
        end
        tick(5);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        tick(2);
        check("mid-frame reset busy", int'(o_busy), 0);
        check("mid-frame reset data", int'(o_data), 0);
        i_rst = 1'b0;
        tick(6);
        compare_all("mid-frame reset");
        par = (^8'h5A) ^ i_parity_odd;
        send_frame(8'h5A, 1'b1, 10, par, t0);
        send_frame(8'h5A, 1'b1, 10, par, t1);
        expect_frame(t0, 8'h5A, 1'b1, 10, 1'b1);
        expect_frame(t1, 8'h5A, 1'b1, 10, 1'b1);
        tick(40);
        compare_all("back-to-back");
        check("back-to-back data", int'(o_data), 8'h5A);

        // Random frame stream against the reference model
        last_good = 8'h5A;
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            div  = int'($urandom_range(4, 20));
            stop = ($urandom_range(0, 7) != 0);
            i_parity_odd = 1'($urandom);
            par  = (^d) ^ i_parity_odd;
            if (P == 1 && $urandom_range(0, 3) == 0) par = ~par;
            par_ok = (par == ((^d) ^ i_parity_odd));
            send_frame(d, stop, div, par, t0);
            expect_frame(t0, d, stop, div, par_ok);
            if (stop) last_good = int'(d);
            if (!stop) tick(2 * div + 6);
            else if ($urandom_range(0, 3) != 0) tick(int'($urandom_range(1, div)));
        end
        tick(100);
        compare_all("random");
        check("random held data", int'(o_data), last_good);
        check("random idle busy", int'(o_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter DIV_W, default 16, giving the width of the runtime baud divisor.
REQ-003 Port i_clk SHALL be an input, 1 bit wide: the system clock; all state changes on its rising edge.
REQ-004 Port i_rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port i_rx SHALL be an input, 1 bit wide: the asynchronous serial line, idle high.
REQ-006 Port i_clk_div SHALL be an input, DIV_W bits wide: clock cycles per bit (legal >= 4).
REQ-007 Port i_parity_odd SHALL be an input, 1 bit wide: 1 = odd parity, 0 = even; used only when UART_RX_PARITY_EN is defined.
REQ-008 Port o_busy SHALL be an output, 1 bit wide: high whenever the FSM is not IDLE.
REQ-009 Port o_data_valid SHALL be an output, 1 bit wide: one-cycle pulse when a frame completes.
REQ-010 Port o_data SHALL be an output, DATA_BITS wide: last received word, held until the next valid frame.
REQ-011 Port o_frame_err SHALL be an output, 1 bit wide: one-cycle pulse on a bad stop bit.
REQ-012 Port o_parity_err SHALL be an output, 1 bit wide: one-cycle pulse on a parity mismatch.
REQ-013 Port o_break SHALL be an output, 1 bit wide: one-cycle pulse on a break condition.

Function
REQ-014 i_rx SHALL pass through a 2-flop synchronizer before any use; "rx" below means the synchronized value.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-016 In IDLE, a 1->0 edge on rx SHALL enter START, latch i_clk_div into an internal divisor, and load the bit counter with (div>>1)-1.
REQ-017 i_clk_div changes mid-frame SHALL have no effect on the frame in progress.
REQ-018 When the bit counter reaches 0 it SHALL reload with div-1; each zero is one sample point.
REQ-019 START sample: rx=1 SHALL be treated as a glitch and return to IDLE with no output; rx=0 SHALL enter DATA.
REQ-020 DATA SHALL sample DATA_BITS bits LSB first into a shift register, then go to PARITY (macro defined) or STOP.
REQ-021 PARITY SHALL compare rx against the XOR of the data bits XOR i_parity_odd; a mismatch sets a sticky frame flag.
REQ-022 STOP sample with rx=1 SHALL, on the next cycle: update o_data, pulse o_data_valid, pulse o_parity_err if the flag is set (data still delivered), then go to IDLE.
REQ-023 STOP sample with rx=0 SHALL pulse o_frame_err, leave o_data unchanged, not pulse o_data_valid, and go to WAIT_IDLE.
REQ-024 A bad stop bit with all data bits 0 SHALL also pulse o_break in the same cycle as o_frame_err.
REQ-025 WAIT_IDLE SHALL return to IDLE only after rx has been 1 for one full div period, so no false start is taken inside a break.
REQ-026 A falling edge already present when returning to IDLE from STOP SHALL start the next frame (back-to-back frames with 1 stop bit supported).
REQ-027 Latency: o_data_valid SHALL rise 2 + (div>>1) + (DATA_BITS + 1 [+1 with parity]) * div + 1 cycles after the i_rx falling edge, within +/-1 cycle for synchronizer phase.
REQ-028 Counter widths SHALL be DIV_W bits, and the bit index SHALL be $clog2(DATA_BITS+1) bits.

Reset
REQ-029 While i_rst is high: FSM SHALL be IDLE; o_busy, o_data_valid, o_frame_err, o_parity_err and o_break SHALL be 0; o_data and the shift register SHALL be 0; synchronizer flops SHALL be 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a new falling edge.

Configuration
REQ-031 When UART_RX_PARITY_EN is defined, the PARITY state and the parity check SHALL be present.
REQ-032 When UART_RX_PARITY_EN is undefined, the PARITY state SHALL be omitted, i_parity_odd SHALL be ignored, and o_parity_err SHALL be tied to 0.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum, the default DATA_BITS and the minimum divisor constant (4).
REQ-034 The synchronizer-plus-edge-detect SHALL be sub-module uart_rx_sync (outputs rx_s and fall_s).

Verification
REQ-035 div=16, frame 0xA5 with stop=1 -> o_data=0xA5, a single o_data_valid pulse at the REQ-027 cycle, no error pulses.
REQ-036 rx low for 3 cycles, div=16 -> return to IDLE, no output pulses, o_busy low within 12 cycles.
REQ-037 0x3C sent with stop=0 -> o_frame_err pulse, o_data keeps its previous value, no o_data_valid.
REQ-038 rx held low for 40 bit times -> exactly one o_break and one o_frame_err pulse, no new frame until rx has been high for 16 cycles.
REQ-039 Macro defined, i_parity_odd=1, 0x01 sent with parity bit 1 -> o_data_valid and o_parity_err pulse together, o_data=0x01.
REQ-040 i_rst pulsed during bit 4, then 0x5A sent back-to-back twice with div=10 -> two valid pulses, o_data=0x5A, no errors.
